// File: rtl/i2c_pkg.sv
// Shared state encoding, slot constants and a bit-select helper for the
// single-byte I2C master.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        SLOT,
        STOP
    } state_t;

    localparam logic [4:0] SLOT_ACK1 = 5'd8;
    localparam logic [4:0] SLOT_ACK2 = 5'd17;
    localparam logic [3:0] BYTE_BITS = 4'd8;

    // Selects bit idx of a byte without a narrower-than-index slice.
    function automatic logic bit_at(input logic [7:0] b, input logic [3:0] idx);
        logic [7:0] shifted;
        shifted = b >> idx;
        return shifted[0];
    endfunction

endpackage

// File: rtl/i2c_edge_detect.sv
// Turns the divider's i2c_clk level into single-cycle rise/fall events on ref_clk.
module i2c_edge_detect (
    input  logic ref_clk,
    input  logic reset_n,
    input  logic i2c_clk,
    output logic rise_evt,
    output logic fall_evt
);

    logic i2c_clk_q;

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            i2c_clk_q <= 1'b0;
        end else begin
            i2c_clk_q <= i2c_clk;
        end
    end

    assign rise_evt = i2c_clk & ~i2c_clk_q;
    assign fall_evt = ~i2c_clk & i2c_clk_q;

endmodule

// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, addr+R/W, ACK, data byte, ACK/NACK, STOP,
// paced by i2c_clk edge events, driving open-drain SCL/SDA enables.
module i2c_master_byte
    import i2c_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter bit NACK_ABORT = 1'b1
) (
    input  logic              ref_clk,
    input  logic              reset_n,
    input  logic              i2c_clk,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic              done,
    output logic              ack_err,
    output logic              scl_out,
    output logic              sda_out,
    input  logic              sda_in
);

    logic rise_evt;
    logic fall_evt;

    i2c_edge_detect u_edge (
        .ref_clk  (ref_clk),
        .reset_n  (reset_n),
        .i2c_clk  (i2c_clk),
        .rise_evt (rise_evt),
        .fall_evt (fall_evt)
    );

    state_t            state_reg, state_next;
    logic [4:0]        slot_reg, slot_next;
    logic [3:0]        bit_cnt_reg, bit_cnt_next;
    logic              slot_open_reg, slot_open_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              rw_reg, rw_next;
    logic [7:0]        wdata_reg, wdata_next;
    logic [7:0]        rx_reg, rx_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              ack_err_reg, ack_err_next;
    logic              scl_reg, scl_next;
    logic              sda_reg, sda_next;
    logic              open_req;
    logic [4:0]        open_idx;

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            slot_reg      <= 5'd0;
            bit_cnt_reg   <= BYTE_BITS - 4'd1;
            slot_open_reg <= 1'b0;
            addr_reg      <= '0;
            rw_reg        <= 1'b0;
            wdata_reg     <= 8'h00;
            rx_reg        <= 8'h00;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            ack_err_reg   <= 1'b0;
            scl_reg       <= 1'b1;
            sda_reg       <= 1'b1;
        end else begin
            state_reg     <= state_next;
            slot_reg      <= slot_next;
            bit_cnt_reg   <= bit_cnt_next;
            slot_open_reg <= slot_open_next;
            addr_reg      <= addr_next;
            rw_reg        <= rw_next;
            wdata_reg     <= wdata_next;
            rx_reg        <= rx_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            ack_err_reg   <= ack_err_next;
            scl_reg       <= scl_next;
            sda_reg       <= sda_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        slot_next      = slot_reg;
        bit_cnt_next   = bit_cnt_reg;
        slot_open_next = slot_open_reg;
        addr_next      = addr_reg;
        rw_next        = rw_reg;
        wdata_next     = wdata_reg;
        rx_next        = rx_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        ack_err_next   = ack_err_reg;
        scl_next       = scl_reg;
        sda_next       = sda_reg;
        open_req       = 1'b0;
        open_idx       = slot_reg + 5'd1;

        case (state_reg)
            IDLE: begin
                scl_next = 1'b1;
                sda_next = 1'b1;
                // The done cycle is already IDLE; a request there is dropped.
                if (start && !done_reg) begin
                    addr_next    = addr;
                    rw_next      = rw;
                    wdata_next   = wdata;
                    ack_err_next = 1'b0;
                    busy_next    = 1'b1;
                    state_next   = START;
                end
            end
            START: begin
                if (fall_evt) begin
                    sda_next       = 1'b0;
                    state_next     = SLOT;
                    slot_next      = 5'd0;
                    slot_open_next = 1'b0;
                    bit_cnt_next   = BYTE_BITS - 4'd1;
                end
            end
            SLOT: begin
                if (rise_evt) begin
                    if (!slot_open_reg) begin
                        open_req = 1'b1;
                        open_idx = 5'd0;
                    end else begin
                        // SCL is still released this cycle: sample, then open the next slot.
                        if (slot_reg == SLOT_ACK1 && sda_in) begin
                            ack_err_next = 1'b1;
                        end
                        if (slot_reg == SLOT_ACK2 && !rw_reg && sda_in) begin
                            ack_err_next = 1'b1;
                        end
                        if (rw_reg && slot_reg > SLOT_ACK1 && slot_reg < SLOT_ACK2) begin
                            rx_next = {rx_reg[6:0], sda_in};
                        end
                        if (slot_reg == SLOT_ACK2 ||
                            (NACK_ABORT && slot_reg == SLOT_ACK1 && sda_in)) begin
                            state_next = STOP;
                            scl_next   = 1'b0;
                            sda_next   = 1'b0;
                        end else begin
                            open_req = 1'b1;
                        end
                    end
                end else if (fall_evt) begin
                    scl_next = 1'b1;
                end
            end
            STOP: begin
                if (fall_evt) begin
                    scl_next = 1'b1;
                end else if (rise_evt) begin
                    sda_next   = 1'b1;
                    state_next = IDLE;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (open_req) begin
            scl_next       = 1'b0;
            slot_next      = open_idx;
            slot_open_next = 1'b1;
            if (open_idx == SLOT_ACK1 || open_idx == SLOT_ACK2) begin
                sda_next = 1'b1;
            end else begin
                if (open_idx < SLOT_ACK1) begin
                    sda_next = bit_at({addr_reg, rw_reg}, bit_cnt_reg);
                end else begin
                    sda_next = rw_reg ? 1'b1 : bit_at(wdata_reg, bit_cnt_reg);
                end
                bit_cnt_next = (bit_cnt_reg == 4'd0) ? (BYTE_BITS - 4'd1) : (bit_cnt_reg - 4'd1);
            end
        end
    end

    assign rdata   = rx_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign ack_err = ack_err_reg;
    assign scl_out = scl_reg;
    assign sda_out = sda_reg;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: bus-level slave/monitor, a transaction-level
// reference model, a directed vector table, a reset sequence and random traffic.
module tb_i2c_master_byte;

    localparam bit NACK_ABORT = 1'b1;

    logic       ref_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i2c_clk = 1'b0;
    logic       start   = 1'b0;
    logic       rw      = 1'b0;
    logic [6:0] addr    = 7'h00;
    logic [7:0] wdata   = 8'h00;
    logic [7:0] rdata;
    logic       busy, done, ack_err, scl_out, sda_out, sda_in;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic       nack_addr;
        logic       nack_data;
        logic [7:0] rbyte;
        logic       exp_ack_err;
        logic [7:0] exp_rdata;
        int         exp_pulses;
        int         glitch_at;
        bit         poke_done;
    } vec_t;

    vec_t tbl[7];

    // Slave configuration and bus observation state
    logic        cfg_nack_addr = 1'b0;
    logic        cfg_nack_data = 1'b0;
    logic [7:0]  cfg_rbyte     = 8'h00;
    logic        slv_drive     = 1'b1;
    logic        slv_active    = 1'b0;
    logic        scl_prev      = 1'b1;
    logic        sda_prev      = 1'b1;
    logic [18:0] cap           = '0;
    int          slv_n         = 0;
    int          start_cnt     = 0;
    int          stop_cnt      = 0;
    int          done_cnt      = 0;

    assign sda_in = sda_out & slv_drive;

    i2c_master_byte #(
        .ADDR_W     (7),
        .NACK_ABORT (NACK_ABORT)
    ) dut (
        .ref_clk (ref_clk),
        .reset_n (reset_n),
        .i2c_clk (i2c_clk),
        .start   (start),
        .rw      (rw),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .scl_out (scl_out),
        .sda_out (sda_out),
        .sda_in  (sda_in)
    );

    always #5 ref_clk = ~ref_clk;

    // i2c_clk period = 8 ref_clk cycles
    int div_cnt = 0;
    always @(posedge ref_clk) begin
        if (div_cnt == 3) begin
            div_cnt <= 0;
            i2c_clk <= ~i2c_clk;
        end else begin
            div_cnt <= div_cnt + 1;
        end
    end

    function automatic logic slave_bit(input int n);
        if (n == 8) return cfg_nack_addr;
        if (cfg_nack_addr) return 1'b1;
        if (n >= 9 && n <= 16 && cap[7]) return cfg_rbyte[16 - n];
        if (n == 17 && !cap[7]) return cfg_nack_data;
        return 1'b1;
    endfunction

    // Slave + protocol monitor, evaluated away from the active edge
    always @(negedge ref_clk) begin
        logic bus_now;
        bus_now = sda_out & slv_drive;
        if (!reset_n) begin
            slv_active = 1'b0;
            slv_drive  = 1'b1;
        end else begin
            if (scl_prev && scl_out && sda_prev && !bus_now) begin
                start_cnt++;
                slv_active = 1'b1;
                slv_n      = 0;
                cap        = '0;
            end else if (scl_prev && scl_out && !sda_prev && bus_now) begin
                stop_cnt++;
                slv_active = 1'b0;
            end
            if (slv_active && !scl_prev && scl_out) begin
                if (slv_n < 19) cap[slv_n] = bus_now;
                slv_n++;
            end
            if (slv_active && scl_prev && !scl_out) slv_drive = slave_bit(slv_n);
            if (done) done_cnt++;
        end
        scl_prev = scl_out;
        sda_prev = sda_out & slv_drive;
    end

    // Transaction-level reference: bus bits seen at each SCL rise, pulse count, ack_err
    function automatic void model(input vec_t v, output logic [18:0] bits,
                                  output int pulses, output logic aerr);
        logic [7:0] ab;
        logic [7:0] data;
        ab   = {v.addr, v.rw};
        bits = '0;
        for (int i = 0; i < 8; i++) bits[i] = ab[7 - i];
        bits[8] = v.nack_addr;
        if (v.nack_addr && NACK_ABORT) begin
            pulses = 10;
            aerr   = 1'b1;
        end else begin
            data = v.rw ? v.rbyte : v.wdata;
            for (int i = 0; i < 8; i++) bits[9 + i] = data[7 - i];
            bits[17] = v.rw ? 1'b1 : v.nack_data;
            pulses   = 19;
            aerr     = v.nack_addr | (~v.rw & v.nack_data);
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        logic [18:0] exp_bits;
        int          exp_p;
        logic        exp_a;
        int          start0, stop0, done0, cyc;
        bit          got_done;
        model(v, exp_bits, exp_p, exp_a);
        cfg_nack_addr = v.nack_addr;
        cfg_nack_data = v.nack_data;
        cfg_rbyte     = v.rbyte;
        repeat (3) @(negedge ref_clk);
        start0 = start_cnt;
        stop0  = stop_cnt;
        done0  = done_cnt;
        rw = v.rw; addr = v.addr; wdata = v.wdata; start = 1'b1;
        @(negedge ref_clk); #1;
        start = 1'b0;
        rw = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
        check({tag, " busy_after_start"}, busy, 1);
        got_done = 0;
        cyc = 0;
        while (!got_done && cyc < 400) begin
            if (v.glitch_at != 0 && cyc == v.glitch_at) begin
                start = 1'b1; addr = 7'h11; wdata = 8'h00; rw = 1'b1;
            end
            @(negedge ref_clk); #1;
            cyc++;
            start = 1'b0;
            if (done) got_done = 1;
        end
        if (!got_done) begin
            check({tag, " done_timeout"}, 0, 1);
            return;
        end
        check({tag, " busy_at_done"}, busy, 0);
        check({tag, " ack_err"}, ack_err, v.exp_ack_err);
        check({tag, " rdata"}, rdata, v.exp_rdata);
        check({tag, " sda_bits"}, cap, exp_bits);
        check({tag, " scl_pulses"}, slv_n, v.exp_pulses);
        check({tag, " start_conds"}, start_cnt - start0, 1);
        check({tag, " stop_conds"}, stop_cnt - stop0, 1);
        if (v.poke_done) start = 1'b1;
        @(negedge ref_clk); #1;
        start = 1'b0;
        check({tag, " done_width"}, done, 0);
        check({tag, " done_count"}, done_cnt - done0, 1);
        if (v.poke_done) begin
            repeat (20) @(negedge ref_clk);
            #1;
            check({tag, " start_at_done_ignored"}, busy, 0);
        end
        $display("txn %s rw=%0d addr=0x%0h ack_err=%0d rdata=0x%0h pulses=%0d",
                 tag, v.rw, v.addr, ack_err, rdata, slv_n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       v;
        logic [7:0] rdata_model;
        logic [18:0] mb;
        int         mp, cyc, done0;
        logic       ma;

        //          rw    addr   wdata  nackA nackD rbyte  expAE expRD pulses glitch poke
        tbl[0] = '{1'b0, 7'h50, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 19, 0,  1'b1};
        tbl[1] = '{1'b1, 7'h50, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 8'h3C, 19, 0,  1'b0};
        tbl[2] = '{1'b0, 7'h50, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 10, 0,  1'b0};
        tbl[3] = '{1'b0, 7'h50, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 8'h3C, 19, 60, 1'b0};
        tbl[4] = '{1'b0, 7'h2A, 8'hC3, 1'b0, 1'b1, 8'h00, 1'b1, 8'h3C, 19, 0,  1'b0};
        tbl[5] = '{1'b1, 7'h7F, 8'h00, 1'b1, 1'b0, 8'h81, 1'b1, 8'h3C, 10, 0,  1'b0};
        tbl[6] = '{1'b1, 7'h01, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 8'h5A, 19, 0,  1'b0};

        repeat (4) @(negedge ref_clk);
        #1;
        check("reset scl_out", scl_out, 1);
        check("reset sda_out", sda_out, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset ack_err", ack_err, 0);
        check("reset rdata", rdata, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Reset asserted while data bit 3 is on the bus
        cfg_nack_addr = 1'b0; cfg_nack_data = 1'b0;
        repeat (3) @(negedge ref_clk);
        rw = 1'b0; addr = 7'h50; wdata = 8'hA5; start = 1'b1;
        @(negedge ref_clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(slv_n == 13 && !scl_out) && cyc < 400) begin
            @(negedge ref_clk); #1;
            cyc++;
        end
        check("rst_mid reach_bit3", cyc < 400, 1);
        done0 = done_cnt;
        @(negedge ref_clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid scl_out", scl_out, 1);
        check("rst_mid sda_out", sda_out, 1);
        check("rst_mid busy", busy, 0);
        check("rst_mid done", done, 0);
        repeat (20) @(negedge ref_clk);
        #1;
        check("rst_mid no_done", done_cnt - done0, 0);
        reset_n = 1'b1;
        $display("txn rst_mid reset during data bit 3, busy=%0d", busy);
        v = tbl[0];
        v.poke_done = 1'b0;
        v.exp_rdata = 8'h00;
        run_txn(v, "after_reset");
        rdata_model = 8'h00;

        for (int i = 0; i < 16; i++) begin
            v.rw        = 1'($urandom);
            v.addr      = 7'($urandom);
            v.wdata     = 8'($urandom);
            v.nack_addr = ($urandom_range(0, 3) == 0);
            v.nack_data = ($urandom_range(0, 3) == 0);
            v.rbyte     = 8'($urandom);
            v.glitch_at = 0;
            v.poke_done = 1'b0;
            model(v, mb, mp, ma);
            v.exp_ack_err = ma;
            v.exp_pulses  = mp;
            if (v.rw && !(v.nack_addr && NACK_ABORT)) rdata_model = v.rbyte;
            v.exp_rdata = rdata_model;
            run_txn(v, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
